// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings (same values ALU_16 decodes)
// and the control FSM state type.
package alu_seq_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_e;
endpackage

// File: rtl/alu_seq_if.sv
// Issue-side request and writeback-side result handshake of alu_seq.
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             z;
  logic             v;
  logic             n;
  logic             c;

  modport master (output in_valid, alu_op, alu_a, alu_b, out_ready,
                  input  in_ready, out_valid, alu_out, z, v, n, c);
  modport slave  (input  in_valid, alu_op, alu_a, alu_b, out_ready,
                  output in_ready, out_valid, alu_out, z, v, n, c);
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// done/product are combinational so the owner latches the last step on the same edge.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH:0]     sum;

  // Multiplier sits in the low half and drains out to the right as the product fills in.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nxt = {sum, acc[WIDTH-1:1]};
  end

  assign done    = (cnt == CW'(1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
    end else if (cnt != '0) begin
      acc <= acc_nxt;
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU: single-cycle logic/arith/shift ops plus an iterative MUL.
// Result and flags are held in DONE until the writeback side takes them.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  state_e             state;
  logic               out_valid_r, z_r, v_r, n_r, c_r;
  logic [WIDTH-1:0]   out_r;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   res;
  logic               cf, vf;
  logic [WIDTH:0]     add_t, sub_t, shl_t, shr_t;
  logic [SHAMT_W-1:0] k;

  assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.alu_op == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.alu_a),
    .b       (bus.alu_b),
    .done    (mul_done),
    .product (product)
  );

  // Shifts carry one extra bit so the last bit shifted out lands in a fixed position;
  // a zero shift amount naturally leaves that bit clear.
  assign k     = bus.alu_b[SHAMT_W-1:0];
  assign add_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign sub_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
  assign shl_t = {1'b0, bus.alu_a} << k;
  assign shr_t = {bus.alu_a, 1'b0} >> k;

  always_comb begin
    res = '0;
    cf  = 1'b0;
    vf  = 1'b0;
    case (bus.alu_op)
      ALU_ADD: begin
        {cf, res} = add_t;
        vf = (bus.alu_a[WIDTH-1] == bus.alu_b[WIDTH-1]) && (res[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      ALU_SUB: begin
        {cf, res} = sub_t;
        vf = (bus.alu_a[WIDTH-1] != bus.alu_b[WIDTH-1]) && (res[WIDTH-1] != bus.alu_a[WIDTH-1]);
      end
      ALU_AND: res = bus.alu_a & bus.alu_b;
      ALU_OR:  res = bus.alu_a | bus.alu_b;
      ALU_XOR: res = bus.alu_a ^ bus.alu_b;
      ALU_SHL: begin
        res = shl_t[WIDTH-1:0];
        cf  = shl_t[WIDTH];
      end
      ALU_SHR: begin
        res = shr_t[WIDTH:1];
        cf  = shr_t[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_r <= 1'b0;
      out_r       <= '0;
      {z_r, v_r, n_r, c_r} <= '0;
    end else if (accept) begin
      if (bus.alu_op == ALU_MUL) begin
        state       <= MUL_RUN;
        out_valid_r <= 1'b0;
      end else begin
        state       <= DONE;
        out_valid_r <= 1'b1;
        out_r       <= res;
        z_r         <= (res == '0);
        n_r         <= res[WIDTH-1];
        v_r         <= vf;
        c_r         <= cf;
      end
    end else begin
      case (state)
        MUL_RUN: if (mul_done) begin
          state       <= DONE;
          out_valid_r <= 1'b1;
          out_r       <= product[WIDTH-1:0];
          z_r         <= (product[WIDTH-1:0] == '0);
          n_r         <= product[WIDTH-1];
          v_r         <= |product[2*WIDTH-1:WIDTH];
          c_r         <= 1'b0;
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.alu_out   = out_r;
  assign bus.z         = z_r;
  assign bus.v         = v_r;
  assign bus.n         = n_r;
  assign bus.c         = c_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors for each op class, handshake timing,
// backpressure with same-cycle re-issue, and reset abort of a running MUL.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   err = 0;

  alu_seq_if #(.WIDTH(16)) bus ();
  alu_seq #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Present a request just after an edge, hold it through one edge, then drop it.
  task automatic apply(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.alu_a = a; bus.alu_b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vec++; if ({bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== 21'h0) begin err++;
      $display("FAIL reset_outputs got=%h exp=0", {bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c}); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  // alu_out,z,v,n,c compared as one 20-bit word
  task automatic test_sub_overflow();
    apply(ALU_SUB, 16'h8000, 16'h0001);
    vec++; if (bus.out_valid !== 1'b1) begin err++; $display("FAIL sub_latency out_valid=%b exp=1", bus.out_valid); end
    vec++; if ({bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {16'h7fff, 4'b0100}) begin err++;
      $display("FAIL sub_ovf got=%h exp=%h", {bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {16'h7fff, 4'b0100}); end
    consume();
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL sub_drain out_valid=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_carry_borrow();
    apply(ALU_ADD, 16'hffff, 16'h0001);
    vec++; if ({bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {16'h0000, 4'b1001}) begin err++;
      $display("FAIL add_carry got=%h exp=%h", {bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {16'h0000, 4'b1001}); end
    consume();
    apply(ALU_SUB, 16'h0001, 16'h0002);
    vec++; if ({bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {16'hffff, 4'b0011}) begin err++;
      $display("FAIL sub_borrow got=%h exp=%h", {bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {16'hffff, 4'b0011}); end
    consume();
    apply(ALU_AND, 16'hf0f0, 16'hff00);
    vec++; if ({bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {16'hf000, 4'b0010}) begin err++;
      $display("FAIL and got=%h exp=%h", {bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {16'hf000, 4'b0010}); end
    consume();
  endtask

  task automatic test_mul();
    int early;
    early = 0;
    apply(ALU_MUL, 16'h0003, 16'h0005);
    vec++; if (bus.in_ready !== 1'b0) begin err++; $display("FAIL mul_in_ready got=%b exp=0", bus.in_ready); end
    for (int i = 1; i < 16; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) early++;
    end
    vec++; if (early != 0) begin err++; $display("FAIL mul_busy cycles_wrong=%0d exp=0", early); end
    @(posedge clk); #1;
    vec++; if (bus.out_valid !== 1'b1) begin err++; $display("FAIL mul_latency out_valid=%b exp=1 at 16 cycles", bus.out_valid); end
    vec++; if ({bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {16'h000f, 4'b0000}) begin err++;
      $display("FAIL mul_3x5 got=%h exp=%h", {bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {16'h000f, 4'b0000}); end
    consume();
    apply(ALU_MUL, 16'h0100, 16'h0100);
    repeat (16) @(posedge clk);
    #1;
    vec++; if ({bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {1'b1, 16'h0000, 4'b1100}) begin err++;
      $display("FAIL mul_ovf got=%h exp=%h", {bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {1'b1, 16'h0000, 4'b1100}); end
    consume();
    apply(ALU_MUL, 16'hffff, 16'hffff);
    repeat (16) @(posedge clk);
    #1;
    vec++; if ({bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {1'b1, 16'h0001, 4'b0100}) begin err++;
      $display("FAIL mul_max got=%h exp=%h", {bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {1'b1, 16'h0001, 4'b0100}); end
    consume();
  endtask

  task automatic test_shift();
    logic [15:0] sa [4] = '{16'h8001, 16'h0003, 16'h1234, 16'h8000};
    logic [15:0] sb [4] = '{16'h0001, 16'h0001, 16'h0000, 16'h000f};
    logic [2:0]  so [4] = '{ALU_SHL, ALU_SHR, ALU_SHL, ALU_SHR};
    logic [19:0] se [4] = '{{16'h0002, 4'b0001}, {16'h0001, 4'b0001}, {16'h1234, 4'b0000}, {16'h0001, 4'b0000}};
    for (int i = 0; i < 4; i++) begin
      apply(so[i], sa[i], sb[i]);
      vec++; if ({bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== se[i]) begin err++;
        $display("FAIL shift_%0d got=%h exp=%h", i, {bus.alu_out, bus.z, bus.v, bus.n, bus.c}, se[i]); end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    apply(ALU_ADD, 16'h1234, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({bus.out_valid, bus.in_ready, bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {2'b10, 16'h1235, 4'b0000}) bad++;
    end
    vec++; if (bad != 0) begin err++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.alu_op = ALU_XOR; bus.alu_a = 16'h00ff; bus.alu_b = 16'h0f0f;
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL b2b_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    vec++; if ({bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {1'b1, 16'h0ff0, 4'b0000}) begin err++;
      $display("FAIL b2b_xor got=%h exp=%h", {bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {1'b1, 16'h0ff0, 4'b0000}); end
    consume();
  endtask

  task automatic test_reset_abort();
    apply(ALU_MUL, 16'h0003, 16'h0005);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if ({bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== 21'h0) begin err++;
      $display("FAIL abort_outputs got=%h exp=0", {bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c}); end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin err++; $display("FAIL abort_in_ready got=%b exp=1", bus.in_ready); end
    repeat (20) @(posedge clk);
    #1;
    vec++; if (bus.out_valid !== 1'b0) begin err++; $display("FAIL abort_no_result out_valid=%b exp=0", bus.out_valid); end
    apply(ALU_ADD, 16'h0002, 16'h0001);
    vec++; if ({bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c} !== {1'b1, 16'h0003, 4'b0000}) begin err++;
      $display("FAIL abort_add got=%h exp=%h", {bus.out_valid, bus.alu_out, bus.z, bus.v, bus.n, bus.c}, {1'b1, 16'h0003, 4'b0000}); end
    consume();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.alu_op = ALU_ADD; bus.alu_a = '0; bus.alu_b = '0;
    test_reset();
    @(posedge clk); #1;
    test_sub_overflow();
    test_carry_borrow();
    test_mul();
    test_shift();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
